mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single memory port (`mem_read`/`mem_write`/`mem_resp` handshake, 16-bit data, 2-bit byte enable) between two requesters: instruction fetch (I, read-only) and data access (D, read/write).
- Sits between the `mp3` datapath's fetch/load-store paths and the memory model.
- Registers the winning request and holds it stable on the memory side until `mem_resp`.
- Routes the response back to the winning requester only.

Parameters:
- ADDR_WIDTH, 16, address width of all ports.
- DATA_WIDTH, 16, data width; byte enable width is DATA_WIDTH/8.
- STARVE_LIMIT, 4, consecutive D grants while I is waiting before I is forced next; range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_read  in  1  I read request; held until i_resp.
- i_address  in  ADDR_WIDTH  I address.
- i_rdata  out  DATA_WIDTH  I read data; valid when i_resp=1.
- i_resp  out  1  I completion pulse, 1 cycle.
- d_read  in  1  D read request; held until d_resp.
- d_write  in  1  D write request; held until d_resp.
- d_byte_enable  in  DATA_WIDTH/8  D write byte enables.
- d_address  in  ADDR_WIDTH  D address.
- d_wdata  in  DATA_WIDTH  D write data.
- d_rdata  out  DATA_WIDTH  D read data; valid when d_resp=1.
- d_resp  out  1  D completion pulse, 1 cycle.
- mem_resp  in  1  memory completion.
- mem_rdata  in  DATA_WIDTH  memory read data.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- mem_byte_enable  out  DATA_WIDTH/8  memory byte enables.
- mem_address  out  ADDR_WIDTH  memory address.
- mem_wdata  out  DATA_WIDTH  memory write data.

Behaviour:
- Reset:
  - Asynchronous; state=IDLE, starve_cnt=0, last_grant=D.
  - All outputs 0, including address, wdata and byte enables.
  - Reset mid-transaction abandons it; no resp is issued.
- States: IDLE, SERVE_I, SERVE_D.
- IDLE:
  - Evaluate requests each cycle.
  - On grant, capture address, wdata, byte enable and op into registers; move to SERVE_x next edge.
  - mem_read/mem_write are low in IDLE.
- Request flags:
  - I request = i_read.
  - D request = d_read|d_write.
  - d_read&d_write together is a protocol violation; write wins, read ignored.
- Fixed-priority arbitration: D beats I on contention, unless starve_cnt==STARVE_LIMIT, in which case I wins.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each D grant made while i_read=1.
  - Clears on any I grant, or on any IDLE cycle with i_read=0.
- SERVE_x:
  - mem_read/mem_write driven from the captured op.
  - mem_address, mem_wdata and mem_byte_enable come from registers and stay stable until mem_resp.
  - I grant drives mem_byte_enable = all ones and mem_wdata = 0.
- Completion:
  - When mem_resp=1, combinationally assert x_resp=1 and x_rdata=mem_rdata in that same cycle.
  - Next state is IDLE.
  - The non-granted port's resp stays 0 and its rdata stays 0.
- Latency:
  - Request seen in IDLE at cycle N gives the memory strobe at N+1.
  - With mem_resp at N+k, x_resp is also at N+k.
  - Minimum 2 cycles per transaction; one IDLE bubble between back-to-back transactions.
- Requester rule: deassert the request in the cycle after resp. The arbiter re-samples in IDLE.
- mem_resp outside SERVE_x is ignored.
- A request change during SERVE_x does not alter the captured transaction.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined:
  - Contention is resolved round-robin: the port that is not last_grant wins.
  - last_grant updates on every grant.
  - starve_cnt logic is removed; STARVE_LIMIT is unused.
- Undefined: fixed D priority with the starvation limit, as above.

Test Plan:
- Reset mid-SERVE_D: assert rst_n=0 while mem_write=1 → all outputs 0 the same cycle; d_resp never pulses; after release, state is IDLE.
- Single I read (i_read=1, i_address=16'h0040, memory returns 16'h1234 after 3 cycles) → mem_read=1 from the next cycle with mem_address=16'h0040 and mem_byte_enable=2'b11; i_resp=1 with i_rdata=16'h1234 in the mem_resp cycle; d_resp stays 0.
- D byte write (d_write=1, d_byte_enable=2'b10, d_address=16'h0100, d_wdata=16'hAB00) → mem_write=1 with identical captured values; changing d_wdata mid-transaction does not alter mem_wdata; d_resp pulses once.
- Simultaneous i_read and d_read, both held → D served first (MEM_ARB_RR_EN undefined).
- Continuous D traffic with I waiting, STARVE_LIMIT=4 → grant sequence D,D,D,D,I,D...
- MEM_ARB_RR_EN defined, both ports requesting continuously → grants alternate I,D,I,D starting with I after reset (last_grant=D).

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: instruction fetch (read-only) and data access share one memory port.
// Define MEM_ARB_RR_EN for round-robin contention; default is D priority with an I starvation limit.
module mem_arbiter #(
  parameter int ADDR_WIDTH   = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_read,
  input  logic [ADDR_WIDTH-1:0]   i_address,
  output logic [DATA_WIDTH-1:0]   i_rdata,
  output logic                    i_resp,
  input  logic                    d_read,
  input  logic                    d_write,
  input  logic [DATA_WIDTH/8-1:0] d_byte_enable,
  input  logic [ADDR_WIDTH-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_resp,
  input  logic                    mem_resp,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
  output logic [ADDR_WIDTH-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]   mem_wdata
);
  localparam int BE_W = DATA_WIDTH/8;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  typedef struct packed {
    logic                  wr;
    logic [BE_W-1:0]       be;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q, req_nxt;
  logic   idle, i_req, d_req, grant_i, grant_d;

  assign idle  = (state == IDLE);
  assign i_req = i_read;
  assign d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
  logic last_grant_d, last_grant_d_nxt;

  // On contention the port that did not win last time goes first.
  assign grant_i = idle && i_req && (!d_req || last_grant_d);

  always_comb begin
    last_grant_d_nxt = last_grant_d;
    if (grant_i)      last_grant_d_nxt = 1'b0;
    else if (grant_d) last_grant_d_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_grant_d <= 1'b1;
    else        last_grant_d <= last_grant_d_nxt;
  end
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0] starve_cnt, starve_nxt;

  // D wins ties until I has been passed over LIMIT times in a row.
  assign grant_i = idle && i_req && (!d_req || starve_cnt == LIMIT);

  always_comb begin
    starve_nxt = starve_cnt;
    if (idle) begin
      if (grant_i || !i_read)                  starve_nxt = '0;
      else if (grant_d && starve_cnt != LIMIT) starve_nxt = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) starve_cnt <= '0;
    else        starve_cnt <= starve_nxt;
  end
`endif

  assign grant_d = idle && d_req && !grant_i;

  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    case (state)
      IDLE: begin
        if (grant_i) begin
          state_nxt = SERVE_I;
          req_nxt   = '{wr: 1'b0, be: {BE_W{1'b1}}, addr: i_address, wdata: '0};
        end else if (grant_d) begin
          state_nxt = SERVE_D;
          // write wins when both d_read and d_write are raised
          req_nxt   = '{wr: d_write, be: d_byte_enable, addr: d_address, wdata: d_wdata};
        end
      end
      SERVE_I, SERVE_D: if (mem_resp) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      req_q <= '0;
    end else begin
      state <= state_nxt;
      req_q <= req_nxt;
    end
  end

  assign mem_read        = (state == SERVE_I) || (state == SERVE_D && !req_q.wr);
  assign mem_write       = (state == SERVE_D) && req_q.wr;
  assign mem_address     = req_q.addr;
  assign mem_wdata       = req_q.wdata;
  assign mem_byte_enable = req_q.be;

  // Completion is steered combinationally to the owner of the current transaction only.
  assign i_resp  = (state == SERVE_I) && mem_resp;
  assign d_resp  = (state == SERVE_D) && mem_resp;
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queue-driven requesters, a latency-programmable memory responder,
// a transaction-level model checked every cycle, and directed literal checks.
module tb_mem_arbiter;
  localparam int LIM = 4;

  logic        clk = 0, rst_n = 0;
  logic        i_read = 0, d_read = 0, d_write = 0;
  logic [15:0] i_address = 0, d_address = 0, d_wdata = 0;
  logic [1:0]  d_byte_enable = 0;
  logic [15:0] i_rdata, d_rdata, mem_address, mem_wdata;
  logic        i_resp, d_resp, mem_read, mem_write;
  logic [1:0]  mem_byte_enable;
  logic        mem_resp = 0;
  logic [15:0] mem_rdata = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_byte_enable(d_byte_enable),
    .d_address(d_address), .d_wdata(d_wdata), .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_byte_enable), .mem_address(mem_address), .mem_wdata(mem_wdata)
  );

  int total = 0, bad = 0;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } dreq_t;

  typedef struct {
    logic [15:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    logic        wr;
    int          ncyc;
    logic        ri;
    logic        rd;
    logic [15:0] rdata;
    logic        stable;
  } obs_t;

  logic [15:0] iq[$];
  dreq_t       dq[$];
  bit          i_done = 0, d_done = 0, perturb = 0, stray = 0;
  int          lat = 1;

  // I requester: holds the head of its queue until served, then moves on.
  initial forever begin
    @(posedge clk); #1;
    if (i_done) begin
      if (iq.size() > 0) void'(iq.pop_front());
      i_done = 0;
    end
    if (iq.size() > 0) begin i_read = 1; i_address = iq[0]; end
    else begin i_read = 0; i_address = 0; end
  end

  // D requester; with perturb set it scrambles its data bus while a transaction is in flight.
  initial forever begin
    @(posedge clk); #1;
    if (d_done) begin
      if (dq.size() > 0) void'(dq.pop_front());
      d_done = 0;
    end
    if (dq.size() > 0) begin
      d_write = dq[0].wr; d_read = !dq[0].wr;
      d_byte_enable = dq[0].be; d_address = dq[0].addr; d_wdata = dq[0].wdata;
      if (perturb && (mem_read || mem_write)) begin
        d_wdata = ~dq[0].wdata; d_address = dq[0].addr ^ 16'h00ff;
      end
    end else begin
      d_write = 0; d_read = 0; d_byte_enable = 0; d_address = 0; d_wdata = 0;
    end
  end

  // Memory: answers on the lat-th strobe cycle with data = address ^ 16'h1274.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge clk); #1;
      mem_rdata = 16'($urandom);
      if (!rst_n) begin cnt = 0; mem_resp = 0; end
      else if (mem_read || mem_write) begin
        cnt++;
        mem_resp = (cnt >= lat);
        if (mem_resp) mem_rdata = mem_address ^ 16'h1274;
      end else begin
        cnt = 0; mem_resp = stray;
      end
    end
  end

  // Transaction-level model: who owns the port and what was captured at grant time.
  logic        m_busy = 0, m_isi = 0, m_wr = 0, m_last_d = 1;
  logic [15:0] m_addr = 0, m_wdata = 0;
  logic [1:0]  m_be = 0;
  int          m_starve = 0;
  string       m_log = "";

  function automatic int who_wins(input logic i, input logic d);
`ifdef MEM_ARB_RR_EN
    if (i && d) return m_last_d ? 1 : 2;
`else
    if (i && d) return (m_starve >= LIM) ? 1 : 2;
`endif
    if (i) return 1;
    if (d) return 2;
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_starve <= 0; m_last_d <= 1;
    end else if (m_busy) begin
      if (mem_resp) m_busy <= 0;
    end else begin
      case (who_wins(i_read, d_read || d_write))
        1: begin
          m_busy <= 1; m_isi <= 1; m_wr <= 0; m_addr <= i_address; m_wdata <= 0; m_be <= 2'b11;
          m_log <= {m_log, "I"}; m_last_d <= 0; m_starve <= 0;
        end
        2: begin
          m_busy <= 1; m_isi <= 0; m_wr <= d_write; m_addr <= d_address; m_wdata <= d_wdata;
          m_be <= d_byte_enable; m_log <= {m_log, "D"}; m_last_d <= 1;
          m_starve <= i_read ? ((m_starve < LIM) ? m_starve + 1 : LIM) : 0;
        end
        default: m_starve <= 0;
      endcase
    end
  end

  // Per-cycle compare against the model, plus DUT-side transaction observation.
  obs_t  cur, obs[$];
  bit    in_txn = 0;
  string dut_log = "";
  int    dresp_n = 0, resp_n = 0;

  initial forever begin
    logic e_rd, e_wr, e_ir, e_dr, ok;
    logic [15:0] e_ird, e_drd;
    @(negedge clk);
    e_rd  = m_busy && (m_isi || !m_wr);
    e_wr  = m_busy && !m_isi && m_wr;
    e_ir  = m_busy && m_isi && mem_resp;
    e_dr  = m_busy && !m_isi && mem_resp;
    e_ird = e_ir ? mem_rdata : 16'h0;
    e_drd = e_dr ? mem_rdata : 16'h0;
    ok = (mem_read === e_rd) && (mem_write === e_wr) && (i_resp === e_ir) && (d_resp === e_dr) &&
         (i_rdata === e_ird) && (d_rdata === e_drd) &&
         (!m_busy || (mem_address === m_addr && mem_wdata === m_wdata && mem_byte_enable === m_be));
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL cycle t=%0t got rd=%b wr=%b ir=%b dr=%b a=%h wd=%h be=%b ird=%h drd=%h want rd=%b wr=%b ir=%b dr=%b a=%h wd=%h be=%b ird=%h drd=%h",
               $time, mem_read, mem_write, i_resp, d_resp, mem_address, mem_wdata, mem_byte_enable,
               i_rdata, d_rdata, e_rd, e_wr, e_ir, e_dr, m_addr, m_wdata, m_be, e_ird, e_drd);
    end
    if (i_resp) begin i_done = 1; resp_n++; end
    if (d_resp) begin d_done = 1; resp_n++; dresp_n++; end
    if (!rst_n) in_txn = 0;
    else if (mem_read || mem_write) begin
      if (!in_txn) begin
        in_txn = 1;
        cur = '{addr: mem_address, be: mem_byte_enable, wdata: mem_wdata, wr: mem_write,
                ncyc: 0, ri: 0, rd: 0, rdata: 0, stable: 1};
        if (mem_address[15]) dut_log = {dut_log, "D"};
        else                 dut_log = {dut_log, "I"};
      end
      cur.ncyc++;
      if (mem_address !== cur.addr || mem_wdata !== cur.wdata || mem_byte_enable !== cur.be) cur.stable = 0;
      if (i_resp || d_resp) begin
        cur.ri = i_resp; cur.rd = d_resp; cur.rdata = i_resp ? i_rdata : d_rdata;
        obs.push_back(cur);
        in_txn = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_s(input string nm, input string act, input string exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %s want %s", nm, act, exp);
    end
  endtask

  task automatic wait_obs(input int n);
    int k;
    k = 0;
    while (obs.size() < n && k < 300) begin @(negedge clk); k++; end
    if (obs.size() < n) begin
      total++; bad++;
      $display("FAIL timeout: got %0d transactions want %0d", obs.size(), n);
    end
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_ctl"}, 32'({mem_read, mem_write, mem_byte_enable, i_resp, d_resp}), 32'h0);
    chk({nm, "_addr_wdata"}, {mem_address, mem_wdata}, 32'h0);
    chk({nm, "_rdata"}, {i_rdata, d_rdata}, 32'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 0;
    iq.delete(); dq.delete(); i_done = 0; d_done = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
  endtask

  initial begin
    int b, n, bl, ml, k;
    string e_contend, e_starve, e_alt;
`ifdef MEM_ARB_RR_EN
    e_contend = "ID"; e_starve = "IDDDDDD"; e_alt = "IDIDID";
`else
    e_contend = "DI"; e_starve = "DDDDIDD"; e_alt = "DDDIII";
`endif
    repeat (2) @(posedge clk); #2;
    check_zero("reset");
    rst_n = 1;

    // single I read, memory answers on the third strobe cycle
    lat = 3; b = obs.size();
    iq.push_back(16'h0040);
    wait_obs(b + 1);
    if (obs.size() > b) begin
      chk("i_addr", 32'(obs[b].addr), 32'h0040);
      chk("i_be", 32'(obs[b].be), 32'h3);
      chk("i_wdata", 32'(obs[b].wdata), 32'h0);
      chk("i_op_wr_ri_rd", 32'({obs[b].wr, obs[b].ri, obs[b].rd}), 32'h2);
      chk("i_rdata", 32'(obs[b].rdata), 32'h1234);
      chk("i_cycles", 32'(obs[b].ncyc), 32'd3);
    end

    // D byte write with the requester's bus scrambled mid-transaction
    repeat (3) @(negedge clk);
    lat = 2; perturb = 1; b = obs.size(); n = dresp_n;
    dq.push_back('{addr: 16'h0100, wr: 1'b1, be: 2'b10, wdata: 16'hAB00});
    wait_obs(b + 1);
    repeat (3) @(negedge clk);
    perturb = 0;
    if (obs.size() > b) begin
      chk("d_addr", 32'(obs[b].addr), 32'h0100);
      chk("d_be", 32'(obs[b].be), 32'h2);
      chk("d_wdata", 32'(obs[b].wdata), 32'hAB00);
      chk("d_op_wr_ri_rd", 32'({obs[b].wr, obs[b].ri, obs[b].rd}), 32'h5);
      chk("d_stable", 32'(obs[b].stable), 32'h1);
      chk("d_cycles", 32'(obs[b].ncyc), 32'd2);
    end
    chk("d_resp_once", 32'(dresp_n - n), 32'd1);

    // simultaneous single requests
    do_reset();
    lat = 1; b = obs.size(); bl = dut_log.len(); ml = m_log.len();
    iq.push_back(16'h0010);
    dq.push_back('{addr: 16'h8010, wr: 1'b0, be: 2'b11, wdata: 16'h0});
    wait_obs(b + 2);
    chk_s("contend_dut", dut_log.substr(bl, bl + 1), e_contend);
    chk_s("contend_model", m_log.substr(ml, ml + 1), e_contend);

    // I waiting behind a stream of D reads
    do_reset();
    lat = 2; b = obs.size(); bl = dut_log.len(); ml = m_log.len();
    iq.push_back(16'h0020);
    for (int i = 0; i < 6; i++) dq.push_back('{addr: 16'(16'h8000 + i), wr: 1'b0, be: 2'b11, wdata: 16'h0});
    wait_obs(b + 7);
    chk_s("starve_dut", dut_log.substr(bl, bl + 6), e_starve);
    chk_s("starve_model", m_log.substr(ml, ml + 6), e_starve);

    // both ports busy with three transactions each, mixed D reads/writes
    do_reset();
    lat = 1; b = obs.size(); bl = dut_log.len(); ml = m_log.len();
    for (int i = 0; i < 3; i++) begin
      iq.push_back(16'(16'h0030 + i));
      dq.push_back('{addr: 16'(16'h8030 + i), wr: (i != 1), be: 2'(i + 1), wdata: 16'(16'h5A00 + i)});
    end
    wait_obs(b + 6);
    chk_s("alt_dut", dut_log.substr(bl, bl + 5), e_alt);
    chk_s("alt_model", m_log.substr(ml, ml + 5), e_alt);

    // mem_resp while idle must not complete anything
    repeat (2) @(negedge clk);
    stray = 1; n = resp_n;
    repeat (6) @(negedge clk);
    chk("stray_idle", 32'(resp_n - n), 32'd0);
    lat = 2; b = obs.size();
    dq.push_back('{addr: 16'h8400, wr: 1'b0, be: 2'b01, wdata: 16'h0});
    wait_obs(b + 1);
    repeat (3) @(negedge clk);
    stray = 0;
    chk("stray_one_resp", 32'(resp_n - n), 32'd1);

    // reset in the middle of a D write
    lat = 6; n = dresp_n;
    dq.push_back('{addr: 16'h8200, wr: 1'b1, be: 2'b01, wdata: 16'h00CD});
    k = 0;
    while (!mem_write && k < 50) begin @(negedge clk); k++; end
    chk("midrst_started", 32'(mem_write), 32'h1);
    @(posedge clk); #3;
    rst_n = 0;
    iq.delete(); dq.delete(); i_done = 0; d_done = 0;
    #1 check_zero("midrst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    lat = 1;
    repeat (5) @(negedge clk);
    chk("midrst_no_resp", 32'(dresp_n - n), 32'd0);
    chk("midrst_idle", 32'({mem_read, mem_write}), 32'h0);
    b = obs.size();
    dq.push_back('{addr: 16'h8300, wr: 1'b0, be: 2'b11, wdata: 16'h0});
    wait_obs(b + 1);
    if (obs.size() > b) chk("post_rst_addr", 32'(obs[b].addr), 32'h8300);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
